// File: rtl/tile_sequence_ctrl.sv
// Tile sequencer: fills SEQ_LEN legal tiles from the LFSR, then plays them over valid/ready with a gap.
// Fill takes 2 cycles per LFSR sample; tile_valid holds until tile_ready. Optional macro: NO_REPEAT_EN.
module tile_sequence_ctrl #(
  parameter int SEQ_LEN    = 6,
  parameter int NUM_TILES  = 6,
  parameter int GAP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [2:0] rand_num,
  output logic       rand_step,
  output logic [2:0] tile_num,
  output logic       tile_valid,
  input  logic       tile_ready,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(SEQ_LEN + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(SEQ_LEN - 1);
  localparam logic [2:0]    MAX_TILE = 3'(NUM_TILES);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, STEP, SAMPLE, PLAY, GAP, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] fill_q, fill_d;
  logic [CW-1:0] play_q, play_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [2:0]    seq_q [2**CW];
  logic          accept;
  logic          wr_en;

  // Zero is the LFSR lock-up value and is never a legal tile.
`ifdef NO_REPEAT_EN
  assign accept = (rand_num != 3'd0) && (rand_num <= MAX_TILE) &&
                  !((fill_q != '0) && (rand_num == seq_q[fill_q - CW'(1)]));
`else
  assign accept = (rand_num != 3'd0) && (rand_num <= MAX_TILE);
`endif

  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    play_d     = play_q;
    gap_d      = gap_q;
    rand_step  = 1'b0;
    tile_valid = 1'b0;
    tile_num   = 3'd0;
    busy       = 1'b1;
    done       = 1'b0;
    wr_en      = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = STEP;
          fill_d  = '0;
        end
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) begin
          state_d = STEP;
          fill_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      STEP: begin
        rand_step = 1'b1;
        state_d   = SAMPLE;
      end
      SAMPLE: begin
        state_d = STEP;
        if (accept) begin
          wr_en  = 1'b1;
          fill_d = fill_q + CW'(1);
          if (fill_q == LAST_IDX) begin
            state_d = PLAY;
            play_d  = '0;
          end
        end
      end
      PLAY: begin
        tile_valid = 1'b1;
        tile_num   = seq_q[play_q];
        if (tile_ready) begin
          play_d = play_q + CW'(1);
          if (play_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            state_d = GAP;
            gap_d   = GAP_LOAD;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = PLAY;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      fill_q  <= '0;
      play_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      play_q  <= play_d;
      gap_q   <= gap_d;
    end
  end

  // Sequence storage is deliberately not reset; it is always refilled before play.
  always_ff @(posedge clk) begin
    if (wr_en) seq_q[fill_q] <= rand_num;
  end

endmodule
